// File: rtl/gray_share_arb.sv
// Two-requester round-robin arbiter sharing one RGB-to-gray converter; returns tagged results.
// Grant is combinational (zero latency); results appear LAT cycles after the grant. No response backpressure.
module gray_share_arb #(
    parameter int LAT = 1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iEnable,
    input  logic        iReq0_Valid,
    input  logic [11:0] iReq0_Red,
    input  logic [11:0] iReq0_Green,
    input  logic [11:0] iReq0_Blue,
    input  logic        iReq1_Valid,
    input  logic [11:0] iReq1_Red,
    input  logic [11:0] iReq1_Green,
    input  logic [11:0] iReq1_Blue,
    output logic        oReq0_Ready,
    output logic        oReq1_Ready,
    output logic [11:0] oCvt_Red,
    output logic [11:0] oCvt_Green,
    output logic [11:0] oCvt_Blue,
    input  logic [11:0] iCvt_Gray,
    output logic        oRsp_Valid,
    output logic        oRsp_Id,
    output logic [11:0] oRsp_Gray,
    output logic [15:0] oGrantCnt0,
    output logic [15:0] oGrantCnt1
);

    logic           pri_q, pri_d;
    logic [LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LAT-1:0] tag_id_q, tag_id_d;
    logic [15:0]    cnt0_q, cnt0_d;
    logic [15:0]    cnt1_q, cnt1_d;
    logic           gnt0, gnt1;

    // Pointer breaks the tie only when both requesters are valid.
    assign gnt0 = iRST_n && iEnable && iReq0_Valid && (!iReq1_Valid || !pri_q);
    assign gnt1 = iRST_n && iEnable && iReq1_Valid && (!iReq0_Valid || pri_q);

    assign oReq0_Ready = gnt0;
    assign oReq1_Ready = gnt1;

    always_comb begin
        oCvt_Red   = 12'd0;
        oCvt_Green = 12'd0;
        oCvt_Blue  = 12'd0;
        if (gnt0) begin
            oCvt_Red   = iReq0_Red;
            oCvt_Green = iReq0_Green;
            oCvt_Blue  = iReq0_Blue;
        end else if (gnt1) begin
            oCvt_Red   = iReq1_Red;
            oCvt_Green = iReq1_Green;
            oCvt_Blue  = iReq1_Blue;
        end
    end

    always_comb begin
        pri_d = pri_q;
        if (gnt0)
            pri_d = 1'b1;
        else if (gnt1)
            pri_d = 1'b0;

        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = gnt0 || gnt1;
        tag_id_d[0]  = gnt1;
        for (int i = 1; i < LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        cnt0_d = (gnt0 && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
        cnt1_d = (gnt1 && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            pri_q     <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            cnt0_q    <= 16'd0;
            cnt1_q    <= 16'd0;
        end else begin
            pri_q     <= pri_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    // Gate with reset so outputs read 0 even before the first reset edge clears the tags.
    assign oRsp_Valid = iRST_n && tag_vld_q[LAT-1];
    assign oRsp_Id    = oRsp_Valid && tag_id_q[LAT-1];
    assign oRsp_Gray  = oRsp_Valid ? iCvt_Gray : 12'd0;
    assign oGrantCnt0 = cnt0_q;
    assign oGrantCnt1 = cnt1_q;

endmodule

// File: tb/tb_gray_share_arb.sv
// Drives LAT=1 and LAT=3 instances with the same stimulus and checks both against a cycle reference model.
module tb_gray_share_arb;

    logic        iCLK = 1'b0;
    logic        iRST_n, iEnable;
    logic        iReq0_Valid, iReq1_Valid;
    logic [11:0] iReq0_Red, iReq0_Green, iReq0_Blue;
    logic [11:0] iReq1_Red, iReq1_Green, iReq1_Blue;

    logic        a_r0, a_r1, a_vld, a_id;
    logic [11:0] a_cr, a_cg, a_cb, a_gin, a_gy;
    logic [15:0] a_c0, a_c1;
    logic        b_r0, b_r1, b_vld, b_id;
    logic [11:0] b_cr, b_cg, b_cb, b_gin, b_gy;
    logic [15:0] b_c0, b_c1;
    logic [11:0] b_pipe [2];

    int checks = 0;
    int errors = 0;

    always #5 iCLK = ~iCLK;

    gray_share_arb #(.LAT(1)) u_lat1 (
        .iCLK(iCLK), .iRST_n(iRST_n), .iEnable(iEnable),
        .iReq0_Valid(iReq0_Valid), .iReq0_Red(iReq0_Red), .iReq0_Green(iReq0_Green), .iReq0_Blue(iReq0_Blue),
        .iReq1_Valid(iReq1_Valid), .iReq1_Red(iReq1_Red), .iReq1_Green(iReq1_Green), .iReq1_Blue(iReq1_Blue),
        .oReq0_Ready(a_r0), .oReq1_Ready(a_r1),
        .oCvt_Red(a_cr), .oCvt_Green(a_cg), .oCvt_Blue(a_cb), .iCvt_Gray(a_gin),
        .oRsp_Valid(a_vld), .oRsp_Id(a_id), .oRsp_Gray(a_gy),
        .oGrantCnt0(a_c0), .oGrantCnt1(a_c1)
    );

    gray_share_arb #(.LAT(3)) u_lat3 (
        .iCLK(iCLK), .iRST_n(iRST_n), .iEnable(iEnable),
        .iReq0_Valid(iReq0_Valid), .iReq0_Red(iReq0_Red), .iReq0_Green(iReq0_Green), .iReq0_Blue(iReq0_Blue),
        .iReq1_Valid(iReq1_Valid), .iReq1_Red(iReq1_Red), .iReq1_Green(iReq1_Green), .iReq1_Blue(iReq1_Blue),
        .oReq0_Ready(b_r0), .oReq1_Ready(b_r1),
        .oCvt_Red(b_cr), .oCvt_Green(b_cg), .oCvt_Blue(b_cb), .iCvt_Gray(b_gin),
        .oRsp_Valid(b_vld), .oRsp_Id(b_id), .oRsp_Gray(b_gy),
        .oGrantCnt0(b_c0), .oGrantCnt1(b_c1)
    );

    function automatic logic [11:0] to_gray(input logic [11:0] r, g, b);
        int unsigned s;
        s = 306 * r + 601 * g + 117 * b;
        return 12'(s >> 10);
    endfunction

    // Converter models: LAT pipeline stages fed by each instance's own oCvt_*.
    always @(posedge iCLK) begin
        a_gin     <= to_gray(a_cr, a_cg, a_cb);
        b_pipe[0] <= to_gray(b_cr, b_cg, b_cb);
        b_pipe[1] <= b_pipe[0];
        b_gin     <= b_pipe[1];
    end

    // Reference model state: arbitration pointer, counters, per-cycle grant history.
    int          cyc = 0;
    int          last_rst = -1;
    logic        pri_m = 1'b0;
    logic [15:0] cnt0_m = 16'd0, cnt1_m = 16'd0;
    logic        hv [8];
    logic        hid [8];
    logic [11:0] hg [8];
    logic        e_r0, e_r1;
    logic [11:0] e_cr, e_cg, e_cb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_dut(input int lat, input string p, input logic r0, r1,
                             input logic [11:0] cr, cg, cb, input logic vld, id,
                             input logic [11:0] gy, input logic [15:0] c0, c1);
        int  g;
        logic ev;
        g  = cyc - lat;
        ev = iRST_n && g >= 0 && g > last_rst && hv[g % 8];
        chk({p, " ready0"}, 32'(r0), 32'(e_r0));
        chk({p, " ready1"}, 32'(r1), 32'(e_r1));
        chk({p, " cvt"}, {cr, cg, cb, 4'd0} >> 4, {e_cr, e_cg, e_cb, 4'd0} >> 4);
        chk({p, " rsp_vld"}, 32'(vld), 32'(ev));
        chk({p, " rsp_id"}, 32'(id), ev ? 32'(hid[g % 8]) : 32'd0);
        chk({p, " rsp_gray"}, 32'(gy), ev ? 32'(hg[g % 8]) : 32'd0);
        chk({p, " cnt0"}, 32'(c0), 32'(cnt0_m));
        chk({p, " cnt1"}, 32'(c1), 32'(cnt1_m));
    endtask

    task automatic step(input logic v0, v1, en, rst, input bit fff);
        logic [11:0] px [6];
        logic        gnt, win;
        for (int i = 0; i < 6; i++)
            px[i] = fff ? 12'hFFF : 12'($urandom);
        iReq0_Valid = v0; iReq0_Red = px[0]; iReq0_Green = px[1]; iReq0_Blue = px[2];
        iReq1_Valid = v1; iReq1_Red = px[3]; iReq1_Green = px[4]; iReq1_Blue = px[5];
        iEnable = en;
        iRST_n  = rst;
        gnt  = rst && en && (v0 || v1);
        win  = (v0 && v1) ? pri_m : v1;
        e_r0 = gnt && !win;
        e_r1 = gnt && win;
        if (!gnt)     {e_cr, e_cg, e_cb} = 36'd0;
        else if (win) {e_cr, e_cg, e_cb} = {px[3], px[4], px[5]};
        else          {e_cr, e_cg, e_cb} = {px[0], px[1], px[2]};
        @(negedge iCLK);
        check_dut(1, "L1", a_r0, a_r1, a_cr, a_cg, a_cb, a_vld, a_id, a_gy, a_c0, a_c1);
        check_dut(3, "L3", b_r0, b_r1, b_cr, b_cg, b_cb, b_vld, b_id, b_gy, b_c0, b_c1);
        @(posedge iCLK);
        hv[cyc % 8]  = gnt;
        hid[cyc % 8] = win;
        hg[cyc % 8]  = to_gray(e_cr, e_cg, e_cb);
        if (!rst) begin
            pri_m = 1'b0; cnt0_m = 16'd0; cnt1_m = 16'd0; last_rst = cyc;
        end else if (gnt) begin
            pri_m = !win;
            if (win) cnt1_m = (cnt1_m == 16'hFFFF) ? cnt1_m : cnt1_m + 16'd1;
            else     cnt0_m = (cnt0_m == 16'hFFFF) ? cnt0_m : cnt0_m + 16'd1;
        end
        cyc++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin hv[i] = 1'b0; hid[i] = 1'b0; hg[i] = 12'd0; end
        iRST_n = 1'b0; iEnable = 1'b1; iReq0_Valid = 1'b0; iReq1_Valid = 1'b0;
        iReq0_Red = '0; iReq0_Green = '0; iReq0_Blue = '0;
        iReq1_Red = '0; iReq1_Green = '0; iReq1_Blue = '0;
        @(posedge iCLK); #1;

        // Reset held with requests pending: nothing granted.
        repeat (2) step(1, 1, 1, 0, 0);

        // Single requester, white pixels.
        repeat (4) step(1, 0, 1, 1, 1);
        repeat (4) step(0, 0, 1, 1, 0);
        chk("single cnt0", 32'(a_c0), 32'd4);

        // Contention from reset.
        step(0, 0, 1, 0, 0);
        repeat (6) step(1, 1, 1, 1, 0);
        repeat (4) step(0, 0, 1, 1, 0);
        chk("contend cnt1", 32'(b_c1), 32'd3);

        // Enable drop in the middle of contention.
        step(1, 1, 1, 1, 0);
        step(1, 1, 0, 1, 0);
        repeat (3) step(1, 1, 1, 1, 0);
        repeat (4) step(0, 0, 1, 1, 0);

        // Lone requester-1 grant, then reset mid-flight.
        step(0, 1, 1, 1, 0);
        repeat (4) step(0, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        repeat (4) step(0, 0, 1, 1, 0);
        chk("rst cnt0", 32'(b_c0), 32'd0);

        // Randomized traffic with occasional disable and reset.
        repeat (400) step(1'($urandom), 1'($urandom), ($urandom % 8) != 0, ($urandom % 40) != 0, 0);

        // Saturation of requester-0 counter.
        step(0, 0, 1, 0, 0);
        repeat (65537) step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("sat cnt0 L1", 32'(a_c0), 32'hFFFF);
        chk("sat cnt0 L3", 32'(b_c0), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
